// File: rtl/pipe_game_pkg.sv
// Shared types and constants for the pipe game: FSM states and BCD score types.
package pipe_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  typedef logic [3:0]  bcd_digit_t;
  typedef logic [11:0] bcd_score_t;

  localparam bcd_score_t SCORE_MAX = 12'h999;

  // Saturating single-step BCD increment, used to predict a score one edge ahead.
  function automatic bcd_score_t bcd_inc(input bcd_score_t value);
    bcd_score_t result;
    result = value;
    if (value != SCORE_MAX) begin
      if (value[3:0] != 4'd9) begin
        result[3:0] = value[3:0] + 4'd1;
      end else begin
        result[3:0] = 4'd0;
        if (value[7:4] != 4'd9) begin
          result[7:4] = value[7:4] + 4'd1;
        end else begin
          result[7:4]  = 4'd0;
          result[11:8] = value[11:8] + 4'd1;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Three-digit BCD counter with synchronous clear, increment enable and
// saturation at 999.
module bcd_counter
  import pipe_game_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_inc,
  output bcd_score_t o_value
);

  bcd_score_t value_reg;
  bcd_score_t value_next;
  logic [2:0] carry;

  // Blocking the first carry at 999 freezes every digit, giving saturation.
  assign carry[0] = i_inc && (value_reg != SCORE_MAX);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      bcd_digit_t digit;
      assign digit = value_reg[gi*4 +: 4];
      assign value_next[gi*4 +: 4] = i_clr    ? 4'd0 :
                                     carry[gi] ? ((digit == 4'd9) ? 4'd0 : digit + 4'd1) :
                                                 digit;
      if (gi < 2) begin : g_carry
        assign carry[gi+1] = carry[gi] && (digit == 4'd9);
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign o_value = value_reg;

endmodule

// File: rtl/pipe_collide_score.sv
// Bird/pipe collision, IDLE/PLAY/OVER game FSM and BCD scoring.
// Define HIGH_SCORE_EN to keep a best-score register on o_high_score.
module pipe_collide_score
  import pipe_game_pkg::*;
#(
  parameter int BIRD_X    = 160,
  parameter int BIRD_SIZE = 16,
  parameter int D_HEIGHT  = 480,
  parameter int HIT_TICKS = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_tick,
  input  logic        i_start,
  input  logic [11:0] i_bird_y,
  input  logic [11:0] i_p_x1,
  input  logic [11:0] i_p_x2,
  input  logic [11:0] i_p_y1,
  input  logic [11:0] i_p_y2,
  input  logic        i_point_add,
  output logic [1:0]  o_state,
  output logic        o_pipe_rst,
  output logic        o_hit,
  output logic [11:0] o_score,
  output logic [11:0] o_high_score
);

  localparam logic signed [12:0] BX1  = 13'(BIRD_X - BIRD_SIZE);
  localparam logic signed [12:0] BX2  = 13'(BIRD_X + BIRD_SIZE);
  localparam logic signed [12:0] BSZ  = 13'(BIRD_SIZE);
  localparam logic signed [12:0] DH   = 13'(D_HEIGHT);
  localparam logic [3:0]         HIT_LAST = 4'(HIT_TICKS - 1);

  logic signed [12:0] by1, by2, px1, px2, py1, py2;
  logic               x_ovl, pipe_hit, oob;
  state_t             state;
  logic [3:0]         hit_cnt;
  logic               hit_reg, pipe_rst_reg;
  logic               go_play, go_over, score_inc;
  bcd_score_t         score;

  assign by1 = $signed({1'b0, i_bird_y}) - BSZ;
  assign by2 = $signed({1'b0, i_bird_y}) + BSZ;
  assign px1 = $signed({1'b0, i_p_x1});
  assign px2 = $signed({1'b0, i_p_x2});
  assign py1 = $signed({1'b0, i_p_y1});
  assign py2 = $signed({1'b0, i_p_y2});

  assign x_ovl    = (BX2 >= px1) && (BX1 <= px2);
  assign pipe_hit = x_ovl && ((by1 < py1) || (by2 > py2));
  assign oob      = (by1 < 13'sd0) || (by2 >= DH);

  assign go_play   = (state != PLAY) && i_start;
  assign go_over   = (state == PLAY) && i_tick && (oob || (pipe_hit && (hit_cnt == HIT_LAST)));
  assign score_inc = (state == PLAY) && i_point_add;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      hit_cnt      <= '0;
      hit_reg      <= 1'b0;
      pipe_rst_reg <= 1'b1;
    end else begin
      hit_reg <= go_over;
      case (state)
        IDLE, OVER: begin
          if (i_start) begin
            state        <= PLAY;
            hit_cnt      <= '0;
            pipe_rst_reg <= 1'b0;
          end
        end
        PLAY: begin
          if (i_tick) begin
            hit_cnt <= pipe_hit ? hit_cnt + 4'd1 : 4'd0;
            if (go_over) begin
              state        <= OVER;
              pipe_rst_reg <= 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          pipe_rst_reg <= 1'b1;
        end
      endcase
    end
  end

  bcd_counter u_score (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (go_play),
    .i_inc   (score_inc),
    .o_value (score)
  );

`ifdef HIGH_SCORE_EN
  bcd_score_t high_score_reg;
  bcd_score_t final_score;

  // The final score includes a point arriving on the game-ending cycle.
  assign final_score = score_inc ? bcd_inc(score) : score;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      high_score_reg <= '0;
    end else if (go_over && (final_score > high_score_reg)) begin
      high_score_reg <= final_score;
    end
  end

  assign o_high_score = high_score_reg;
`else
  assign o_high_score = 12'h000;
`endif

  assign o_state    = state;
  assign o_pipe_rst = pipe_rst_reg;
  assign o_hit      = hit_reg;
  assign o_score    = score;

endmodule

// File: tb/tb_pipe_collide_score.sv
// Scoreboard bench for pipe_collide_score: expectations are queued when a cycle
// is driven and compared after the following clock edge.
module tb_pipe_collide_score;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;
`ifdef HIGH_SCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        point_add = 1'b0;
  logic [11:0] bird_y = 12'd240;
  logic [11:0] p_x1 = 12'd150, p_x2 = 12'd170, p_y1 = 12'd120, p_y2 = 12'd360;
  logic [1:0]  state;
  logic        pipe_rst, hit;
  logic [11:0] score, high_score;

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [11:0] score;
    logic        hit;
    logic [11:0] hs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_hs = 0;

  always #5 clk = ~clk;

  pipe_collide_score dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_tick       (tick),
    .i_start      (start),
    .i_bird_y     (bird_y),
    .i_p_x1       (p_x1),
    .i_p_x2       (p_x2),
    .i_p_y1       (p_y1),
    .i_p_y2       (p_y2),
    .i_point_add  (point_add),
    .o_state      (state),
    .o_pipe_rst   (pipe_rst),
    .o_hit        (hit),
    .o_score      (score),
    .o_high_score (high_score)
  );

  function automatic logic [11:0] to_bcd(input int n);
    int v;
    v = (n > 999) ? 999 : n;
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] es, input logic [11:0] escore,
                           input logic eh, input logic [11:0] ehs);
    check({tag, "_state"}, 12'(state), 12'(es));
    check({tag, "_pipe_rst"}, 12'(pipe_rst), 12'(es != S_PLAY));
    check({tag, "_hit"}, 12'(hit), 12'(eh));
    check({tag, "_score"}, score, escore);
    check({tag, "_high"}, high_score, ehs);
  endtask

  // Drive one cycle of inputs, queue the expected outputs after the next edge.
  task automatic cyc(input string tag, input logic st, input logic pt, input logic tk,
                     input logic [1:0] es, input int ep, input logic eh);
    exp_t e;
    start     = st;
    point_add = pt;
    tick      = tk;
    e.tag   = tag;
    e.st    = es;
    e.score = to_bcd(ep);
    e.hit   = eh;
    e.hs    = HS_EN ? to_bcd(exp_hs) : 12'h000;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check_all(e.tag, e.st, e.score, e.hit, e.hs);
    $display("txn %s state=%0d score=%h hit=%b high=%h", e.tag, state, score, hit, high_score);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all("reset", S_IDLE, 12'h000, 1'b0, 12'h000);
    rst = 1'b0;

    // Game A: twelve points, ends out of bounds at the bottom.
    cyc("a_start", 1, 0, 0, S_PLAY, 0, 0);
    for (int i = 1; i <= 12; i++) cyc("a_pt", 0, 1, 0, S_PLAY, i, 0);
    p_x1 = 12'd400; p_x2 = 12'd460; bird_y = 12'd470;
    exp_hs = 12;
    cyc("a_oob_bottom", 0, 0, 1, S_OVER, 12, 1);
    bird_y = 12'd240;
    cyc("a_pt_in_over", 0, 1, 0, S_OVER, 12, 0);
    cyc("a_over_hold", 0, 0, 1, S_OVER, 12, 0);

    // Game B: lower score, last point lands on the game-ending tick.
    cyc("b_start", 1, 0, 0, S_PLAY, 0, 0);
    for (int i = 1; i <= 3; i++) cyc("b_pt", 0, 1, 0, S_PLAY, i, 0);
    bird_y = 12'd10;
    cyc("b_oob_top_pt", 0, 1, 1, S_OVER, 4, 1);
    cyc("b_over", 0, 0, 0, S_OVER, 4, 0);
    bird_y = 12'd240;
    cyc("b_restart_drop_pt", 1, 1, 0, S_PLAY, 0, 0);

    // Game C: pipe collision confirmation and exact-edge cases.
    p_x1 = 12'd150; p_x2 = 12'd170; p_y1 = 12'd120; p_y2 = 12'd360;
    cyc("c_safe", 0, 0, 1, S_PLAY, 0, 0);
    p_y1 = 12'd250;
    cyc("c_hit_tick1", 0, 0, 1, S_PLAY, 0, 0);
    cyc("c_no_tick", 0, 0, 0, S_PLAY, 0, 0);
    p_y1 = 12'd120;
    cyc("c_clear_tick", 0, 0, 1, S_PLAY, 0, 0);
    p_y1 = 12'd250;
    cyc("c_hit_again", 0, 0, 1, S_PLAY, 0, 0);
    p_y1 = 12'd224;
    cyc("c_touch_top", 0, 0, 1, S_PLAY, 0, 0);
    p_y1 = 12'd120; p_y2 = 12'd256;
    cyc("c_touch_bottom", 0, 0, 1, S_PLAY, 0, 0);
    p_y2 = 12'd255;
    cyc("c_bottom_hit", 0, 0, 1, S_PLAY, 0, 0);
    p_x1 = 12'd177;
    cyc("c_x_miss", 0, 0, 1, S_PLAY, 0, 0);
    p_x1 = 12'd176;
    cyc("c_x_touch_hit", 0, 0, 1, S_PLAY, 0, 0);
    cyc("c_start_ignored", 1, 1, 0, S_PLAY, 1, 0);
    for (int i = 2; i <= 20; i++) cyc("c_pt", 0, 1, 0, S_PLAY, i, 0);
    exp_hs = 21;
    cyc("c_confirm_hit", 0, 1, 1, S_OVER, 21, 1);
    cyc("c_over", 0, 0, 1, S_OVER, 21, 0);

    // Game D: decimal carry and saturation.
    p_x1 = 12'd150; p_y2 = 12'd360;
    cyc("d_start", 1, 0, 0, S_PLAY, 0, 0);
    for (int i = 1; i <= 1000; i++) cyc("d_pt", 0, 1, 0, S_PLAY, i, 0);
    p_x1 = 12'd400; p_x2 = 12'd460; bird_y = 12'd470;
    exp_hs = 999;
    cyc("d_oob", 0, 0, 1, S_OVER, 999, 1);

    // Game E: asynchronous reset in the middle of play.
    bird_y = 12'd240;
    cyc("e_start", 1, 0, 0, S_PLAY, 0, 0);
    for (int i = 1; i <= 5; i++) cyc("e_pt", 0, 1, 0, S_PLAY, i, 0);
    point_add = 1'b0;
    #2 rst = 1'b1;
    #1 check_all("e_async_rst", S_IDLE, 12'h000, 1'b0, 12'h000);
    @(negedge clk);
    check_all("e_rst_held", S_IDLE, 12'h000, 1'b0, 12'h000);
    rst = 1'b0;
    exp_hs = 0;
    cyc("e_restart", 1, 0, 0, S_PLAY, 0, 0);
    cyc("e_pt_after", 0, 1, 0, S_PLAY, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_collide_score.md
# pipe_collide_score

Game-state and scoring block on the receiving end of the pipe generator interface. It consumes the pipe rectangle edges and point pulse, checks the bird box against the pipe and the screen bounds, and runs the IDLE/PLAY/OVER state machine. It keeps a saturating 3-digit BCD score and drives the pipe generator's reset so the pipe is held parked outside play.

## Interface
- BIRD_X, 160: bird centre x (fixed column)
- BIRD_SIZE, 16: bird half-size, x and y
- D_HEIGHT, 480: display height; bottom bound
- HIT_TICKS, 2: consecutive overlapping ticks needed to confirm a pipe collision (1..15)
- i_clk  in  1  base clock
- i_rst  in  1  reset, asynchronous, active-high
- i_tick  in  1  animation strobe; collision is evaluated only on cycles with i_tick=1
- i_start  in  1  start/restart request, level or pulse
- i_bird_y  in  12  bird centre y
- i_p_x1, i_p_x2, i_p_y1, i_p_y2  in  12 each  pipe left/right edges, hole top/bottom
- i_point_add  in  1  one-cycle pulse per pipe passed
- o_state  out  2  0=IDLE, 1=PLAY, 2=OVER
- o_pipe_rst  out  1  high whenever o_state != PLAY; wired to the pipe generator's i_rst
- o_hit  out  1  one-cycle pulse on entry to OVER
- o_score  out  12  BCD {hundreds, tens, units}
- o_high_score  out  12  BCD best score (see Configuration)

## Operation
- Reset values: o_state=IDLE, o_pipe_rst=1, o_hit=0, o_score=0x000, o_high_score=0x000, hit counter=0.
- Bird box: bx1=BIRD_X-BIRD_SIZE, bx2=BIRD_X+BIRD_SIZE, by1=i_bird_y-BIRD_SIZE, by2=i_bird_y+BIRD_SIZE.
  - Compute in 13-bit signed.
  - Negative by1 counts as out of bounds.
- x_ovl = (bx2 >= i_p_x1) && (bx1 <= i_p_x2).
- pipe_hit = x_ovl && (by1 < i_p_y1 || by2 > i_p_y2). Touching an edge exactly is not a hit.
- oob = (by1 < 0) || (by2 >= D_HEIGHT).
- IDLE: on i_start, go to PLAY and clear the score to 0x000.
- PLAY, each cycle with i_tick=1:
  - If pipe_hit, increment the hit counter; otherwise clear it.
  - Go to OVER if oob, or if pipe_hit and the counter value before the increment is HIT_TICKS-1.
- PLAY, i_start: ignored.
- OVER: on i_start, go to PLAY and clear the score. The hit counter is cleared on every entry to PLAY.
- Score:
  - Each cycle with i_point_add=1 while o_state=PLAY, increment the score in BCD with decimal carry.
  - The score saturates at 0x999.
  - i_point_add outside PLAY is ignored.
- Simultaneous events:
  - i_point_add in the same cycle as the PLAY→OVER transition is counted.
  - i_start in the same cycle as i_point_add in OVER clears the score; the point is dropped.

## Timing
- All outputs are registered.
- A transition triggered at edge N is visible at edge N+1.
- o_pipe_rst follows o_state in the same cycle.
- o_hit is high for exactly the first cycle that o_state=OVER.
- o_score reflects i_point_add one cycle later.
- Collision confirmation latency: HIT_TICKS ticks of sustained overlap, then one clock.
- Reset asserted mid-game forces reset values immediately (asynchronously), regardless of state.

## Configuration
- HIGH_SCORE_EN defined:
  - On the cycle of each PLAY→OVER transition, o_high_score takes the final score, including any same-cycle point, if that score is greater than the stored value.
  - BCD compares as unsigned.
  - It survives restarts and is cleared only by i_rst.
- HIGH_SCORE_EN undefined: no high-score register; o_high_score is tied to 0x000. The port list is unchanged.

## Structure
- Package pipe_game_pkg holds:
  - the state enum (IDLE/PLAY/OVER, 2-bit)
  - the BCD digit typedef (4-bit) and 3-digit score typedef (12-bit)
  - the constant SCORE_MAX=0x999
- Sub-module bcd_counter: 3-digit BCD counter with synchronous clear, increment enable and saturation at 0x999. Async reset on i_rst.

## Test plan
- Reset, i_start pulse, i_point_add pulsed 12 times in PLAY → o_score=0x012. A 13th pulse with o_state=OVER → score stays 0x012.
- Score at 0x099 plus one point → 0x100. Score at 0x999 plus one point → stays 0x999.
- i_bird_y=240, pipe x1=150, x2=170, y1=120, y2=360, HIT_TICKS=2 → no hit.
  - Change y1=250: one tick leaves the state PLAY; the second tick gives OVER, with o_hit high for one cycle and o_pipe_rst=1.
- i_bird_y=470 on one tick → OVER on the next edge (oob). Same result for i_bird_y=10 (by1 negative).
- HIGH_SCORE_EN: game 1 ends at 0x007, game 2 at 0x003 → o_high_score=0x007. Without the macro → 0x000.
- i_rst asserted mid-PLAY at score 0x005 → all outputs at reset values immediately. After release, i_start → PLAY with score 0x000.
